// File: rtl/calc_ctrl_fsm.sv
// calc_ctrl_fsm
//   Control unit for the calculator datapath. It turns debounced button pulses
//   into op selection, result capture, the val_bcd conversion handshake and the
//   display-source select. It owns the op register.
//
//   Optional feature macro: CALC_CONV_TIMEOUT_EN
//     defined   : CONV gives up after TIMEOUT_CYC cycles without conv_rdy and
//                 moves to ERR (err=1, disp_sel=3).
//     undefined : CONV waits for conv_rdy indefinitely, err is tied low.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enter_p      debounced enter pulse (1 cycle)
//   back_p       debounced back pulse (1 cycle)
//   up_p         debounced up pulse (1 cycle)
//   down_p       debounced down pulse (1 cycle)
//   calc_result  combinational Calculator output
//   conv_rdy     val_bcd conversion done
//   op           op code to Calculator / op_seg
//   conv_en      enable to val_bcd, high in every CONV cycle
//   conv_val     zero-extended captured result handed to val_bcd
//   result_q     captured result
//   disp_sel     0=blank 1=op mnemonic 2=BCD result 3=error
//   err          conversion timeout flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | display blank, waiting for enter
// OP    | choosing an op with up/down, enter captures the result
// CONV  | val_bcd running, waiting for conv_rdy
// RES   | showing the BCD result, enter recaptures, back returns to OP
// ERR   | conversion timed out, enter/back return to IDLE

module calc_ctrl_fsm #(
    parameter int OP_W        = 3,
    parameter int NUM_OPS     = 8,
    parameter int RES_W       = 8,
    parameter int CONV_W      = 12,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter_p,
    input  logic              back_p,
    input  logic              up_p,
    input  logic              down_p,
    input  logic [RES_W-1:0]  calc_result,
    input  logic              conv_rdy,
    output logic [OP_W-1:0]   op,
    output logic              conv_en,
    output logic [CONV_W-1:0] conv_val,
    output logic [RES_W-1:0]  result_q,
    output logic [1:0]        disp_sel,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP   = 3'd1,
        CONV = 3'd2,
        RES  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_MAX = OP_W'(NUM_OPS - 1);

    state_t state;

`ifdef CALC_CONV_TIMEOUT_EN
    // Down-counter loaded on CONV entry; terminal count 0 means the
    // TIMEOUT_CYC-th cycle in CONV has been reached without conv_rdy.
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] tmr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            conv_en  <= 1'b0;
            conv_val <= '0;
            result_q <= '0;
            disp_sel <= 2'd0;
`ifdef CALC_CONV_TIMEOUT_EN
            err      <= 1'b0;
            tmr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enter_p) begin
                        state    <= OP;
                        disp_sel <= 2'd1;
                    end
                end

                OP: begin
                    if (enter_p) begin
                        result_q <= calc_result;
                        conv_val <= CONV_W'(calc_result);
                        conv_en  <= 1'b1;
                        state    <= CONV;
`ifdef CALC_CONV_TIMEOUT_EN
                        tmr      <= TMR_LOAD;
`endif
                    end else if (back_p) begin
                        state    <= IDLE;
                        disp_sel <= 2'd0;
                    end else if (up_p && !down_p) begin
                        op <= (op == OP_MAX) ? '0 : op + 1'b1;
                    end else if (down_p && !up_p) begin
                        op <= (op == '0) ? OP_MAX : op - 1'b1;
                    end
                end

                CONV: begin
                    // conv_rdy beats both abort and timeout on the same cycle
                    if (conv_rdy) begin
                        conv_en  <= 1'b0;
                        disp_sel <= 2'd2;
                        state    <= RES;
                    end else if (back_p) begin
                        conv_en  <= 1'b0;
                        disp_sel <= 2'd1;
                        state    <= OP;
`ifdef CALC_CONV_TIMEOUT_EN
                    end else if (tmr == '0) begin
                        conv_en  <= 1'b0;
                        disp_sel <= 2'd3;
                        err      <= 1'b1;
                        state    <= ERR;
                    end else begin
                        tmr <= tmr - 1'b1;
`endif
                    end
                end

                RES: begin
                    if (enter_p) begin
                        result_q <= calc_result;
                        conv_val <= CONV_W'(calc_result);
                        conv_en  <= 1'b1;
                        state    <= CONV;
`ifdef CALC_CONV_TIMEOUT_EN
                        tmr      <= TMR_LOAD;
`endif
                    end else if (back_p) begin
                        disp_sel <= 2'd1;
                        state    <= OP;
                    end
                end

`ifdef CALC_CONV_TIMEOUT_EN
                ERR: begin
                    if (enter_p || back_p) begin
                        err      <= 1'b0;
                        disp_sel <= 2'd0;
                        state    <= IDLE;
                    end
                end
`endif

                default: begin
                    conv_en  <= 1'b0;
                    disp_sel <= 2'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifndef CALC_CONV_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// tb_calc_ctrl_fsm
//   Directed bench for calc_ctrl_fsm: op selection with wrap, capture and
//   conversion handshake, pulse priority, abort, async reset mid-conversion
//   and the conversion timeout (or its absence in the default build).

module tb_calc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enter_p, back_p, up_p, down_p;
    logic [7:0]  calc_result;
    logic        conv_rdy;
    logic [2:0]  op;
    logic        conv_en;
    logic [11:0] conv_val;
    logic [7:0]  result_q;
    logic [1:0]  disp_sel;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calc_ctrl_fsm #(
        .OP_W(3), .NUM_OPS(8), .RES_W(8), .CONV_W(12), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .enter_p(enter_p), .back_p(back_p), .up_p(up_p), .down_p(down_p),
        .calc_result(calc_result), .conv_rdy(conv_rdy),
        .op(op), .conv_en(conv_en), .conv_val(conv_val),
        .result_q(result_q), .disp_sel(disp_sel), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply a one-cycle combination of pulses, then sample 1ns after the edge.
    task automatic step(input logic e, input logic b, input logic u, input logic d, input logic r);
        enter_p  = e;
        back_p   = b;
        up_p     = u;
        down_p   = d;
        conv_rdy = r;
        @(posedge clk);
        #1;
        enter_p  = 1'b0;
        back_p   = 1'b0;
        up_p     = 1'b0;
        down_p   = 1'b0;
        conv_rdy = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op"},       32'(op),       32'h0);
        check({tag, "_conv_en"},  32'(conv_en),  32'h0);
        check({tag, "_conv_val"}, 32'(conv_val), 32'h0);
        check({tag, "_result_q"}, 32'(result_q), 32'h0);
        check({tag, "_disp_sel"}, 32'(disp_sel), 32'h0);
        check({tag, "_err"},      32'(err),      32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        enter_p     = 1'b0;
        back_p      = 1'b0;
        up_p        = 1'b0;
        down_p      = 1'b0;
        conv_rdy    = 1'b0;
        calc_result = 8'h00;
        #23;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: IDLE ignores up, enter -> OP, up x3, down x4 with wrap
        step(0, 0, 1, 0, 0);
        check("idle_up_ignored", 32'(op), 32'h0);
        step(1, 0, 0, 0, 0);
        check("op_disp", 32'(disp_sel), 32'h1);
        check("op_conv_en", 32'(conv_en), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        check("up3", 32'(op), 32'h3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        check("down4_wrap", 32'(op), 32'h7);
        step(0, 0, 1, 0, 0);
        check("up_wrap", 32'(op), 32'h0);
        step(0, 0, 0, 1, 0);
        check("down_wrap", 32'(op), 32'h7);

        // 2: capture and conversion handshake
        calc_result = 8'hC8;
        step(1, 0, 0, 0, 0);
        check("conv_en_on", 32'(conv_en), 32'h1);
        check("conv_val", 32'(conv_val), 32'h0C8);
        check("result_q", 32'(result_q), 32'hC8);
        calc_result = 8'h11;
        step(0, 0, 1, 0, 0);
        check("conv_op_frozen", 32'(op), 32'h7);
        check("conv_no_recapture", 32'(result_q), 32'hC8);
        check("conv_en_hold", 32'(conv_en), 32'h1);
        step(0, 0, 0, 0, 1);
        check("res_disp", 32'(disp_sel), 32'h2);
        check("res_conv_en", 32'(conv_en), 32'h0);

        // 3: RES back -> OP, up+down no change, enter+back -> CONV
        step(0, 1, 0, 0, 0);
        check("res_back_disp", 32'(disp_sel), 32'h1);
        check("res_back_op", 32'(op), 32'h7);
        step(0, 0, 1, 1, 0);
        check("up_down_same", 32'(op), 32'h7);
        step(1, 1, 0, 0, 0);
        check("enter_beats_back", 32'(conv_en), 32'h1);
        check("recapture_11", 32'(result_q), 32'h11);
        check("conv_val_11", 32'(conv_val), 32'h011);

        // 4: abort, conv_rdy vs back, RES recapture, async reset mid-CONV
        step(0, 1, 0, 0, 0);
        check("abort_conv_en", 32'(conv_en), 32'h0);
        check("abort_disp", 32'(disp_sel), 32'h1);
        calc_result = 8'h5A;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        check("rdy_beats_back", 32'(disp_sel), 32'h2);
        calc_result = 8'h33;
        step(1, 0, 0, 0, 0);
        check("res_recapture", 32'(result_q), 32'h33);
        check("res_recap_en", 32'(conv_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 5: timeout behaviour
        calc_result = 8'h42;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t_conv_entry", 32'(conv_en), 32'h1);
`ifdef CALC_CONV_TIMEOUT_EN
        idle_cycles(15);
        check("t_still_conv", 32'(conv_en), 32'h1);
        check("t_no_err_yet", 32'(err), 32'h0);
        idle_cycles(1);
        check("t_err", 32'(err), 32'h1);
        check("t_err_disp", 32'(disp_sel), 32'h3);
        check("t_err_conv_en", 32'(conv_en), 32'h0);
        step(1, 0, 0, 0, 0);
        check("t_err_clear", 32'(err), 32'h0);
        check("t_idle_disp", 32'(disp_sel), 32'h0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle_cycles(15);
        step(0, 0, 0, 0, 1);
        check("t_rdy_on_timeout", 32'(disp_sel), 32'h2);
        check("t_rdy_no_err", 32'(err), 32'h0);
`else
        idle_cycles(120);
        check("no_timeout_conv_en", 32'(conv_en), 32'h1);
        check("no_timeout_disp", 32'(disp_sel), 32'h1);
        check("no_timeout_err", 32'(err), 32'h0);
        step(0, 0, 0, 0, 1);
        check("late_rdy_res", 32'(disp_sel), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
